// File: rtl/sdram_sched_pkg.sv
// Shared types, width defaults and helpers for the SDRAM access scheduler.
package sdram_sched_pkg;

    localparam int NPORTS_DEF  = 2;
    localparam int ADDR_W_DEF  = 21;
    localparam int DIN_W_DEF   = 8;
    localparam int DOUT_W_DEF  = 16;
    localparam int RD_LAT_DEF  = 2;
    localparam int CREDITS_DEF = 4;
    localparam int PORT_W      = 2;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DIN_W_DEF-1:0]  din;
        logic                  aux;
        logic                  we;
    } sdram_req_t;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
    } rd_tag_t;

    // Round-robin successor of a port index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sdram_access_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Scan from the highest offset down so the lowest offset from ptr wins last.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        grant = '0;
        sum   = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum   = {1'b0, ptr} + (PW+1)'(i);
            idx   = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
            grant = req[idx] ? (ONE << idx) : grant;
        end
    end

endmodule

// File: rtl/sdram_access_scheduler.sv
// Round-robin sharing of one SDRAM controller port with per-port read credits
// and fixed-latency routing of read words back to their requester.
module sdram_access_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int NPORTS  = NPORTS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DIN_W   = DIN_W_DEF,
    parameter int DOUT_W  = DOUT_W_DEF,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int CREDITS = CREDITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sdram_ready,
    input  logic [NPORTS-1:0]        req_valid,
    output logic [NPORTS-1:0]        req_ready,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*DIN_W-1:0]  req_din,
    input  logic [NPORTS-1:0]        req_aux,
    input  logic [NPORTS-1:0]        req_we,
    input  logic [NPORTS-1:0]        rsp_pop,
    output logic [NPORTS-1:0]        rsp_valid,
    output logic [DOUT_W-1:0]        rsp_data,
    output logic [ADDR_W-1:0]        sd_addr,
    output logic [DIN_W-1:0]         sd_din,
    output logic                     sd_aux,
    output logic                     sd_we,
    input  logic [DOUT_W-1:0]        sd_dout,
    output logic                     sched_error
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [NPORTS-1:0] ONE_N = {{(NPORTS-1){1'b0}}, 1'b1};

    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] grant;
    logic [NPORTS-1:0] pop_err;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic              any_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DIN_W-1:0]  sel_din;
    logic              sel_aux;
    logic              sel_we;
    rd_tag_t           pipe [RD_LAT];
    rd_tag_t           tail;

    for (genvar p = 0; p < NPORTS; p++) begin : g_credit
        logic [CW-1:0] credit;
        logic          dec;
        logic          inc;

        assign dec         = grant[p] & ~req_we[p];
        assign pop_err[p]  = rsp_pop[p] & (credit == CW'(CREDITS));
        assign inc         = rsp_pop[p] & ~pop_err[p];
        assign eligible[p] = req_valid[p] & sdram_ready & (req_we[p] | (credit != '0));

        // Credit counter; a pop and a read grant together cancel out.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                credit <= CW'(CREDITS);
            end else if (inc & ~dec) begin
                credit <= credit + CW'(1);
            end else if (dec & ~inc) begin
                credit <= credit - CW'(1);
            end
        end
    end

    rr_arbiter #(.N(NPORTS), .PW(PW)) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;
    assign tail      = pipe[RD_LAT-1];

    // Mux the winning port's request fields.
    always_comb begin
        win      = '0;
        sel_addr = '0;
        sel_din  = '0;
        sel_aux  = 1'b0;
        sel_we   = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            win      = grant[i] ? PW'(i) : win;
            sel_addr = grant[i] ? req_addr[i*ADDR_W +: ADDR_W] : sel_addr;
            sel_din  = grant[i] ? req_din[i*DIN_W +: DIN_W] : sel_din;
            sel_aux  = grant[i] ? req_aux[i] : sel_aux;
            sel_we   = grant[i] ? req_we[i] : sel_we;
        end
    end

    // Issue registers, rr pointer and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_addr     <= '0;
            sd_din      <= '0;
            sd_aux      <= 1'b0;
            sd_we       <= 1'b0;
            ptr         <= '0;
            sched_error <= 1'b0;
        end else begin
            sched_error <= sched_error | (|pop_err);
            if (any_grant) begin
                sd_addr <= sel_addr;
                sd_din  <= sel_din;
                sd_aux  <= sel_aux;
                sd_we   <= sel_we;
                ptr     <= PW'(rr_next(int'(win), NPORTS));
            end else begin
                sd_we   <= 1'b0;
            end
        end
    end

    // Read-tag pipe aligned with the controller's read latency, plus response routing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            pipe[0].valid <= any_grant & ~sel_we;
            pipe[0].port  <= PORT_W'(win);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            rsp_valid <= tail.valid ? (ONE_N << tail.port) : '0;
            rsp_data  <= tail.valid ? sd_dout : rsp_data;
        end
    end

endmodule
